// File: rtl/ann_stim_sequencer.sv
// Streams a packed weight/data image from SRAM into the ANN core and hands results back to the host.
// state  | meaning
// IDLE   | waiting for start
// RD_W1  | reading weight1 words
// RD_W2  | reading weight2 words
// RD_D   | reading data points of the current sample
// RD_T   | target read issued, draining until in_valid_t is out
// WAIT   | waiting for out_valid (bounded by TIMEOUT)
// FIN    | done pulse, back to IDLE
module ann_stim_sequencer #(
    parameter int DATA_W  = 32,
    parameter int AW      = 16,
    parameter int N_IN    = 4,
    parameter int N_HID   = 3,
    parameter int TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AW-1:0]     base_addr,
    input  logic [15:0]       num_sample,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err,
    output logic              mem_rd,
    output logic [AW-1:0]     mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              in_valid_w1,
    output logic              in_valid_w2,
    output logic              in_valid_d,
    output logic              in_valid_t,
    output logic [DATA_W-1:0] weight1,
    output logic [DATA_W-1:0] weight2,
    output logic [DATA_W-1:0] data_point,
    output logic [DATA_W-1:0] target,
    input  logic              out_valid,
    input  logic [DATA_W-1:0] out,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic [15:0]       res_idx
);
    localparam logic [15:0] W1_LAST = 16'(N_IN*N_HID - 1);
    localparam logic [15:0] W2_LAST = 16'(N_HID - 1);
    localparam logic [15:0] D_LAST  = 16'(N_IN - 1);
    localparam logic [15:0] T_DRAIN = 16'd2;
    localparam int          TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);
    localparam logic [1:0]  TG_W1 = 2'd0, TG_W2 = 2'd1, TG_D = 2'd2, TG_T = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_RD_W1, S_RD_W2, S_RD_D, S_RD_T, S_WAIT, S_FIN} state_t;

    state_t            r_state;
    logic [AW-1:0]     r_addr;
    logic [15:0]       r_cnt;
    logic [15:0]       r_num;
    logic [15:0]       r_smp;
    logic [TW-1:0]     r_tmr;
    logic [1:0]        r_tag;
    logic              r_pend_v;
    logic [1:0]        r_pend_tag;
    logic              r_busy, r_done, r_mem_rd;
    logic [1:0]        r_err;
    logic [AW-1:0]     r_mem_addr;
    logic              r_v_w1, r_v_w2, r_v_d, r_v_t;
    logic [DATA_W-1:0] r_weight1, r_weight2, r_data_point, r_target;
    logic              r_res_valid;
    logic [DATA_W-1:0] r_res_data;
    logic [15:0]       r_res_idx;

    logic [AW-1:0]     w_addr_nxt;
    logic [15:0]       w_smp_nxt;
    logic              w_sel_w1, w_sel_w2, w_sel_d, w_sel_t;

    assign w_addr_nxt = r_addr + AW'(1);
    assign w_smp_nxt  = r_smp + 16'd1;
    assign w_sel_w1   = r_pend_v && (r_pend_tag == TG_W1);
    assign w_sel_w2   = r_pend_v && (r_pend_tag == TG_W2);
    assign w_sel_d    = r_pend_v && (r_pend_tag == TG_D);
    assign w_sel_t    = r_pend_v && (r_pend_tag == TG_T);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_cnt        <= '0;
            r_num        <= '0;
            r_smp        <= '0;
            r_tmr        <= '0;
            r_tag        <= TG_W1;
            r_pend_v     <= 1'b0;
            r_pend_tag   <= TG_W1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= '0;
            r_mem_rd     <= 1'b0;
            r_mem_addr   <= '0;
            r_v_w1       <= 1'b0;
            r_v_w2       <= 1'b0;
            r_v_d        <= 1'b0;
            r_v_t        <= 1'b0;
            r_weight1    <= '0;
            r_weight2    <= '0;
            r_data_point <= '0;
            r_target     <= '0;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_res_idx    <= '0;
        end else begin
            r_done      <= 1'b0;
            r_res_valid <= 1'b0;
            // Read data returns one cycle after the strobe; register it out one cycle later.
            r_pend_v     <= r_mem_rd;
            r_pend_tag   <= r_tag;
            r_v_w1       <= w_sel_w1;
            r_v_w2       <= w_sel_w2;
            r_v_d        <= w_sel_d;
            r_v_t        <= w_sel_t;
            r_weight1    <= w_sel_w1 ? mem_rdata : '0;
            r_weight2    <= w_sel_w2 ? mem_rdata : '0;
            r_data_point <= w_sel_d  ? mem_rdata : '0;
            r_target     <= w_sel_t  ? mem_rdata : '0;
            if (out_valid && (r_state != S_WAIT)) r_err[1] <= 1'b1;

            case (r_state)
                S_IDLE: if (start) begin
                    r_err      <= '0;
                    r_busy     <= 1'b1;
                    r_num      <= num_sample;
                    r_smp      <= '0;
                    r_mem_rd   <= 1'b1;
                    r_mem_addr <= base_addr;
                    r_addr     <= base_addr + AW'(1);
                    r_tag      <= TG_W1;
                    r_cnt      <= W1_LAST;
                    r_state    <= S_RD_W1;
                end
                S_RD_W1: begin
                    r_mem_addr <= r_addr;
                    r_addr     <= w_addr_nxt;
                    if (r_cnt == 16'd0) begin
                        r_tag   <= TG_W2;
                        r_cnt   <= W2_LAST;
                        r_state <= S_RD_W2;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_RD_W2: begin
                    if (r_cnt != 16'd0) begin
                        r_mem_addr <= r_addr;
                        r_addr     <= w_addr_nxt;
                        r_cnt      <= r_cnt - 16'd1;
                    end else if (r_num == 16'd0) begin
                        r_mem_rd <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_FIN;
                    end else begin
                        r_mem_addr <= r_addr;
                        r_addr     <= w_addr_nxt;
                        r_tag      <= TG_D;
                        r_cnt      <= D_LAST;
                        r_state    <= S_RD_D;
                    end
                end
                S_RD_D: begin
                    r_mem_addr <= r_addr;
                    r_addr     <= w_addr_nxt;
                    if (r_cnt == 16'd0) begin
                        r_tag   <= TG_T;
                        r_cnt   <= T_DRAIN;
                        r_state <= S_RD_T;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_RD_T: begin
                    r_mem_rd <= 1'b0;
                    if (r_cnt == 16'd0) begin
                        r_tmr   <= TMR_LOAD;
                        r_state <= S_WAIT;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_WAIT: begin
                    if (out_valid) begin
                        r_res_valid <= 1'b1;
                        r_res_data  <= out;
                        r_res_idx   <= r_smp;
                        r_smp       <= w_smp_nxt;
                        if (w_smp_nxt == r_num) begin
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            r_mem_rd   <= 1'b1;
                            r_mem_addr <= r_addr;
                            r_addr     <= w_addr_nxt;
                            r_tag      <= TG_D;
                            r_cnt      <= D_LAST;
                            r_state    <= S_RD_D;
                        end
                    end else if (r_tmr == '0) begin
                        r_err[0] <= 1'b1;
                        r_done   <= 1'b1;
                        r_state  <= S_FIN;
                    end else begin
                        r_tmr <= r_tmr - TW'(1);
                    end
                end
                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign mem_rd      = r_mem_rd;
    assign mem_addr    = r_mem_addr;
    assign in_valid_w1 = r_v_w1;
    assign in_valid_w2 = r_v_w2;
    assign in_valid_d  = r_v_d;
    assign in_valid_t  = r_v_t;
    assign weight1     = r_weight1;
    assign weight2     = r_weight2;
    assign data_point  = r_data_point;
    assign target      = r_target;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign res_idx     = r_res_idx;
endmodule

// File: doc/ann_stim_sequencer.md
Name: ann_stim_sequencer

Overview:
- On-chip driver for the ANN core's input protocol; the transmitting end of the in_valid_w1/w2/d/t streams, and the consumer of out_valid/out.
- Reads a packed image from a word-addressed SRAM (1-cycle read latency).
- Streams weight1, then weight2, then per sample the data points and target.
- Captures each result and returns it to the host with the sample index.

Parameters:
DATA_W, 32, IEEE-754 single word width
AW, 16, SRAM address width
N_IN, 4, data points per sample
N_HID, 3, hidden neurons; W1 words = N_IN*N_HID, W2 words = N_HID
TIMEOUT, 1000, max cycles waiting for out_valid per sample

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle launch pulse, honoured only in IDLE
base_addr  in  AW  image base, sampled on start
num_sample  in  16  samples to run, sampled on start
busy  out  1  high from the cycle after start until the done cycle, inclusive
done  out  1  one-cycle completion pulse
err  out  2  sticky; bit0 timeout, bit1 out_valid outside WAIT; cleared on start
mem_rd  out  1  SRAM read strobe
mem_addr  out  AW  SRAM address
mem_rdata  in  DATA_W  read data, valid the cycle after mem_rd
in_valid_w1, in_valid_w2, in_valid_d, in_valid_t  out  1  stream valids to the ANN core
weight1, weight2, data_point, target  out  DATA_W  stream data; zero when the matching valid is low
out_valid  in  1  ANN result valid
out  in  DATA_W  ANN result
res_valid  out  1  one-cycle result strobe
res_data  out  DATA_W  captured out
res_idx  out  16  sample index of res_data, 0-based

Behaviour:
- Reset: all outputs 0, FSM to IDLE, err cleared. An asserted reset mid-run aborts immediately; no done pulse is issued.
- Image layout, addresses mod 2^AW:
  - base .. base+W1-1: weight1
  - next W2 words: weight2
  - then per sample: N_IN data words followed by 1 target word (stride N_IN+1).
- FSM states: IDLE, RD_W1, RD_W2, RD_D, RD_T, WAIT, FIN.
  - IDLE -> RD_W1 on start.
  - RD_W1 -> RD_W2 -> RD_D -> RD_T issue one mem_rd per cycle, back-to-back with no gaps, counters tracking words.
  - RD_T -> WAIT.
  - WAIT -> RD_D (next sample) on out_valid, or FIN after the last sample.
  - FIN: done=1 for one cycle, busy=0, -> IDLE.
  - num_sample=0: RD_W2 -> FIN directly; weights are still sent.
- Latency: read issued in cycle k; the matching in_valid_x and data are registered out in cycle k+2.
  - Streams are therefore contiguous: W1 burst, W2 burst, D burst of N_IN, then a 1-cycle T.
  - Exactly one in_valid_* is high in any cycle.
  - No gap between W2 and the first D.
  - WAIT is entered only after in_valid_t has been driven.
- Weights are sent once per start. Every later sample sends data and target only.
- WAIT:
  - Count cycles from entry. out_valid in WAIT latches out into res_data, pulses res_valid on the next cycle with res_idx = current sample, and increments the sample counter.
  - At count = TIMEOUT with no out_valid: set err[0], go to FIN.
  - A multi-cycle out_valid captures only the first cycle; the remaining cycles set err[1].
- out_valid outside WAIT: ignored for data, sets err[1].
- start while busy: ignored.
- out_valid coinciding with TIMEOUT: the result wins (it is captured and no timeout is flagged).

Test Plan:
- Defaults, num_sample=1, base=0x0100, SRAM[a]=a -> weight1 = 0x100..0x10B over 12 cycles starting 3 cycles after start; weight2 = 0x10C..0x10E; data = 0x10F..0x112; target = 0x113; one valid high per cycle. Then out_valid with out=0x3F800000 -> res_valid, res_data=0x3F800000, res_idx=0, done next cycle.
- num_sample=3, core answers 20 cycles after each in_valid_t -> weights streamed once; second sample's data at 0x114..0x117 and target at 0x118; res_idx 0,1,2; err=0.
- Core never asserts out_valid -> after 1000 WAIT cycles err=2'b01, done pulses, no res_valid.
- base=0xFFFE -> weight1 read from 0xFFFE, 0xFFFF, 0x0000 (address wraps); num_sample=0 -> W1 and W2 streamed, no in_valid_d, done.
- Spurious out_valid during the W1 burst, plus a start pulse mid-run -> err[1]=1, sequence unaffected, second start ignored.
- rst_n low mid-D-burst -> all valids and data lines 0 asynchronously; a new start after release rereads from the new base.
